// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
// Access-type encodings, FSM states and the byte-lane enable/extract functions.
package dmem_pkg;

  localparam int NUM_BYTES = 4;

  typedef enum logic [2:0] {
    DM_WORD   = 3'b000,
    DM_HALF   = 3'b001,
    DM_HALF_U = 3'b010,
    DM_BYTE   = 3'b011,
    DM_BYTE_U = 3'b100
  } dm_ctrl_e;

  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE, SZ_BAD} size_e;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_DATA, S_RMW_RD, S_RMW_MERGE, S_WR, S_ERR, S_DONE
  } state_e;

  typedef struct packed {
    logic [1:0]  lane;
    size_e       sz;
    logic [31:0] wdata;
  } req_t;

  // Signedness is the CPU's business, so both half codes and both byte codes collapse.
  function automatic size_e ctrl_size(logic [2:0] c);
    case (c)
      DM_WORD:              return SZ_WORD;
      DM_HALF, DM_HALF_U:   return SZ_HALF;
      DM_BYTE, DM_BYTE_U:   return SZ_BYTE;
      default:              return SZ_BAD;
    endcase
  endfunction

  function automatic logic [NUM_BYTES-1:0] byte_en(size_e sz, logic [1:0] lane);
    case (sz)
      SZ_WORD: return 4'b1111;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: return 4'b0001 << lane;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(logic [31:0] word, size_e sz, logic [1:0] lane);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (sz)
      SZ_WORD: return word;
      SZ_HALF: return {16'h0000, sh[15:0]};
      SZ_BYTE: return {24'h000000, sh[7:0]};
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// CPU-side request/response bundle of the data-memory port.
interface dmem_if;
  logic        req;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_ctrl;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (output req, mem_w, addr, wdata, dm_ctrl, input rdata, ready, err);
  modport slave  (input req, mem_w, addr, wdata, dm_ctrl, output rdata, ready, err);
endinterface

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: right-justified load extract and byte-enable store merge.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] st_data,
  input  size_e       sz,
  input  logic [1:0]  lane,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [NUM_BYTES-1:0]      be;
  logic [NUM_BYTES-1:0][7:0] rep;

  assign be = byte_en(sz, lane);

  // Replicate store data across the word so each lane just picks its own byte.
  always_comb begin
    rep = st_data;
    case (sz)
      SZ_HALF: rep = {2{st_data[15:0]}};
      SZ_BYTE: rep = {4{st_data[7:0]}};
      default: rep = st_data;
    endcase
  end

  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
    assign merged[8*i +: 8] = be[i] ? rep[i] : rd_word[8*i +: 8];
  end

  assign ld_data = lane_extract(rd_word, sz, lane);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: runs one CPU load/store per request against a word-wide synchronous SRAM.
// Sub-word stores read-modify-write; bad requests complete with err and never touch the SRAM.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  dmem_if.slave             bus,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  localparam logic [32:0] SPAN = 33'(4) << ADDR_W;

  state_e      state_q, state_d;
  req_t        req_q;
  logic [31:0] rdata_q;
  logic [32:0] off;
  size_e       req_sz;
  logic        aligned, req_ok, accept;
  logic [31:0] ld_data, merged;

  // 33-bit offset: an address below BASE_ADDR wraps into bit 32 and fails the span test.
  assign req_sz = ctrl_size(bus.dm_ctrl);
  assign off    = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
  assign req_ok = aligned && (off < SPAN);
  assign accept = (state_q == S_IDLE) && bus.req;

  always_comb begin
    aligned = 1'b0;
    case (req_sz)
      SZ_WORD: aligned = (bus.addr[1:0] == 2'b00);
      SZ_HALF: aligned = !bus.addr[0];
      SZ_BYTE: aligned = 1'b1;
      default: aligned = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (bus.req) begin
          if (!req_ok)                 state_d = S_ERR;
          else if (!bus.mem_w)         state_d = S_RD_ISSUE;
          else if (req_sz == SZ_WORD)  state_d = S_WR;
          else                         state_d = S_RMW_RD;
        end
      S_RD_ISSUE:  state_d = S_RD_DATA;
      S_RD_DATA:   state_d = S_DONE;
      S_RMW_RD:    state_d = S_RMW_MERGE;
      S_RMW_MERGE: state_d = S_WR;
      S_WR:        state_d = S_DONE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.lane  <= bus.addr[1:0];
      req_q.sz    <= req_sz;
      req_q.wdata <= bus.wdata;
    end
  end

  dmem_lane_unit u_lane (
    .rd_word (sram_rdata),
    .st_data (req_q.wdata),
    .sz      (req_q.sz),
    .lane    (req_q.lane),
    .ld_data (ld_data),
    .merged  (merged)
  );

  // SRAM strobes are registered off the next state so they line up with the issue states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      rdata_q    <= '0;
    end else begin
      sram_en <= (state_d == S_RD_ISSUE) || (state_d == S_RMW_RD) || (state_d == S_WR);
      sram_we <= (state_d == S_WR);
      if (accept && req_ok) sram_addr <= off[ADDR_W+1:2];
      if (accept && state_d == S_WR) sram_wdata <= bus.wdata;
      else if (state_q == S_RMW_MERGE) sram_wdata <= merged;
      if (state_q == S_RD_DATA) rdata_q <= ld_data;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = (state_q == S_DONE) || (state_q == S_ERR);
  assign bus.err   = (state_q == S_ERR);

endmodule
